// File: rtl/control_pipeline_unit.sv
// ID-stage control unit: decode into the ID/EX latch, load-use stall, flush bubbles, HALT drain FSM.
// Optional CONTROL_JAL_LINK_EN enables JAL/JALR link decode; otherwise they decode as unknown.
module control_pipeline_unit #(
  parameter int CANT_BITS_INSTRUCTION           = 32,
  parameter int CANT_BITS_ALU_OP                = 2,
  parameter int CANT_BITS_ALU_CONTROL           = 4,
  parameter int CANT_BITS_FLAG_BRANCH           = 3,
  parameter int CANT_BITS_SELECT_BYTES_MEM_DATA = 2,
  parameter int CANT_BITS_REGISTRO              = 5,
  parameter int CANT_ETAPAS_DRAIN               = 3,
  parameter int CANT_BITS_CONTADOR              = 16
) (
  input  logic                                       i_clock,
  input  logic                                       i_soft_reset,
  input  logic [CANT_BITS_INSTRUCTION-1:0]           i_instruction,
  input  logic                                       i_enable_etapa,
  input  logic                                       i_flush,
  output logic                                       o_RegDst,
  output logic                                       o_RegWrite,
  output logic                                       o_ALUSrc,
  output logic                                       o_MemRead,
  output logic                                       o_MemWrite,
  output logic                                       o_MemtoReg,
  output logic [CANT_BITS_ALU_OP-1:0]                o_ALUOp,
  output logic [CANT_BITS_ALU_CONTROL-1:0]           o_ALUCtrl,
  output logic [CANT_BITS_SELECT_BYTES_MEM_DATA-1:0] o_select_bytes_mem_datos,
  output logic [CANT_BITS_FLAG_BRANCH-1:0]           o_flag_branch,
  output logic                                       o_stall,
  output logic                                       o_halted,
  output logic [CANT_BITS_CONTADOR-1:0]              o_contador_instrucciones
);

  localparam int CW = (CANT_ETAPAS_DRAIN > 1) ? $clog2(CANT_ETAPAS_DRAIN) : 1;

  typedef logic [CANT_BITS_ALU_OP-1:0]                aluop_t;
  typedef logic [CANT_BITS_ALU_CONTROL-1:0]           aluc_t;
  typedef logic [CANT_BITS_SELECT_BYTES_MEM_DATA-1:0] sel_t;
  typedef logic [CANT_BITS_FLAG_BRANCH-1:0]           flag_t;
  typedef logic [CANT_BITS_REGISTRO-1:0]              reg_t;

  typedef struct packed {
    logic   reg_dst;
    logic   reg_write;
    logic   alu_src;
    logic   mem_read;
    logic   mem_write;
    logic   mem_to_reg;
    aluop_t alu_op;
    aluc_t  alu_ctrl;
    sel_t   sel;
    flag_t  flag;
  } ctrl_t;

  localparam aluop_t OP_MEM = aluop_t'(0);
  localparam aluop_t OP_BR  = aluop_t'(1);
  localparam aluop_t OP_R   = aluop_t'(2);
  localparam aluop_t OP_IMM = aluop_t'(3);

  localparam aluc_t A_AND  = aluc_t'(4'b0000);
  localparam aluc_t A_OR   = aluc_t'(4'b0001);
  localparam aluc_t A_ADD  = aluc_t'(4'b0010);
  localparam aluc_t A_XOR  = aluc_t'(4'b0011);
  localparam aluc_t A_SUB  = aluc_t'(4'b0110);
  localparam aluc_t A_SLT  = aluc_t'(4'b0111);
  localparam aluc_t A_SLL  = aluc_t'(4'b1000);
  localparam aluc_t A_SRL  = aluc_t'(4'b1001);
  localparam aluc_t A_SRA  = aluc_t'(4'b1010);
  localparam aluc_t A_SLLV = aluc_t'(4'b1011);
  localparam aluc_t A_NOR  = aluc_t'(4'b1100);
  localparam aluc_t A_LUI  = aluc_t'(4'b1101);

  localparam sel_t S_BYTE = sel_t'(2'b00);
  localparam sel_t S_HALF = sel_t'(2'b01);
  localparam sel_t S_WORD = sel_t'(2'b11);

  localparam flag_t F_BEQ  = flag_t'(3'b001);
  localparam flag_t F_BNE  = flag_t'(3'b010);
  localparam flag_t F_J    = flag_t'(3'b011);
  localparam flag_t F_JR   = flag_t'(3'b100);
`ifdef CONTROL_JAL_LINK_EN
  localparam flag_t F_JAL  = flag_t'(3'b101);
  localparam flag_t F_JALR = flag_t'(3'b110);
`endif

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t                        state;
  logic [CW-1:0]                 drain_cnt;
  ctrl_t                         ctrl_q;
  reg_t                          rt_q;
  logic [CANT_BITS_CONTADOR-1:0] count;
  logic                          halted;

  logic [5:0] opcode, funct;
  reg_t       rs, rt;
  ctrl_t      dec;
  logic       known, reads_rt, is_halt, hazard;

  assign opcode  = i_instruction[31:26];
  assign funct   = i_instruction[5:0];
  assign rs      = i_instruction[21 +: CANT_BITS_REGISTRO];
  assign rt      = i_instruction[16 +: CANT_BITS_REGISTRO];
  assign is_halt = (i_instruction == '0);

  always_comb begin
    dec      = '0;
    known    = 1'b0;
    reads_rt = 1'b0;
    case (opcode)
      6'b000000: begin
        reads_rt    = 1'b1;
        known       = 1'b1;
        dec.reg_dst = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op  = OP_R;
        case (funct)
          6'b000000: dec.alu_ctrl = A_SLL;
          6'b000010: dec.alu_ctrl = A_SRL;
          6'b000011: dec.alu_ctrl = A_SRA;
          6'b000100: dec.alu_ctrl = A_SLLV;
          6'b100000, 6'b100001: dec.alu_ctrl = A_ADD;
          6'b100010, 6'b100011: dec.alu_ctrl = A_SUB;
          6'b100100: dec.alu_ctrl = A_AND;
          6'b100101: dec.alu_ctrl = A_OR;
          6'b100110: dec.alu_ctrl = A_XOR;
          6'b100111: dec.alu_ctrl = A_NOR;
          6'b101010: dec.alu_ctrl = A_SLT;
          6'b001000: begin
            dec      = '0;
            dec.flag = F_JR;
          end
`ifdef CONTROL_JAL_LINK_EN
          6'b001001: begin
            dec           = '0;
            dec.reg_dst   = 1'b1;
            dec.reg_write = 1'b1;
            dec.flag      = F_JALR;
          end
`endif
          default: begin
            dec   = '0;
            known = 1'b0;
          end
        endcase
      end
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: begin
        known          = 1'b1;
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_op     = OP_MEM;
        dec.alu_ctrl   = A_ADD;
        dec.sel        = (opcode[1:0] == 2'b11) ? S_WORD : (opcode[0] ? S_HALF : S_BYTE);
      end
      6'b101000, 6'b101001, 6'b101011: begin
        known         = 1'b1;
        reads_rt      = 1'b1;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_op    = OP_MEM;
        dec.alu_ctrl  = A_ADD;
        dec.sel       = (opcode[1:0] == 2'b11) ? S_WORD : (opcode[0] ? S_HALF : S_BYTE);
      end
      6'b000100, 6'b000101: begin
        known        = 1'b1;
        reads_rt     = 1'b1;
        dec.alu_op   = OP_BR;
        dec.alu_ctrl = A_SUB;
        dec.flag     = opcode[0] ? F_BNE : F_BEQ;
      end
      6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        known         = 1'b1;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = OP_IMM;
        case (opcode[2:0])
          3'b000:  dec.alu_ctrl = A_ADD;
          3'b010:  dec.alu_ctrl = A_SLT;
          3'b100:  dec.alu_ctrl = A_AND;
          3'b101:  dec.alu_ctrl = A_OR;
          3'b110:  dec.alu_ctrl = A_XOR;
          default: dec.alu_ctrl = A_LUI;
        endcase
      end
      6'b000010: begin
        known    = 1'b1;
        dec.flag = F_J;
      end
`ifdef CONTROL_JAL_LINK_EN
      // Link register R31 is implied by the JAL flag; RegDst stays 0.
      6'b000011: begin
        known         = 1'b1;
        dec.reg_write = 1'b1;
        dec.flag      = F_JAL;
      end
`endif
      default: ;
    endcase
  end

  assign hazard  = (state == RUN) && !i_flush && ctrl_q.mem_read && (rt_q != '0) &&
                   ((rt_q == rs) || ((rt_q == rt) && reads_rt));
  assign o_stall = i_enable_etapa && hazard;

  always_ff @(posedge i_clock) begin
    if (!i_soft_reset) begin
      state     <= RUN;
      drain_cnt <= '0;
      ctrl_q    <= '0;
      rt_q      <= '0;
      count     <= '0;
      halted    <= 1'b0;
    end else if (i_enable_etapa) begin
      ctrl_q <= '0;
      rt_q   <= '0;
      case (state)
        RUN: begin
          if (!i_flush && !hazard) begin
            if (is_halt) begin
              state     <= DRAIN;
              drain_cnt <= CW'(CANT_ETAPAS_DRAIN - 1);
            end else if (known) begin
              ctrl_q <= dec;
              rt_q   <= rt;
              if (count != {CANT_BITS_CONTADOR{1'b1}}) count <= count + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - CW'(1);
          end
        end
        HALTED: ;
        default: state <= RUN;
      endcase
    end
  end

  assign o_RegDst                 = ctrl_q.reg_dst;
  assign o_RegWrite               = ctrl_q.reg_write;
  assign o_ALUSrc                 = ctrl_q.alu_src;
  assign o_MemRead                = ctrl_q.mem_read;
  assign o_MemWrite               = ctrl_q.mem_write;
  assign o_MemtoReg               = ctrl_q.mem_to_reg;
  assign o_ALUOp                  = ctrl_q.alu_op;
  assign o_ALUCtrl                = ctrl_q.alu_ctrl;
  assign o_select_bytes_mem_datos = ctrl_q.sel;
  assign o_flag_branch            = ctrl_q.flag;
  assign o_halted                 = halted;
  assign o_contador_instrucciones = count;

endmodule

// File: tb/tb_control_pipeline_unit.sv
// Directed bench for control_pipeline_unit: hand-computed control words checked after each edge.
module tb_control_pipeline_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        en, flush;
  logic        reg_dst, reg_write, alu_src, mem_read, mem_write, mem_to_reg;
  logic [1:0]  alu_op;
  logic [3:0]  alu_ctrl;
  logic [1:0]  sel;
  logic [2:0]  flag;
  logic        stall, halted;
  logic [15:0] count;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  control_pipeline_unit dut (
    .i_clock(clk), .i_soft_reset(rst_n), .i_instruction(instr),
    .i_enable_etapa(en), .i_flush(flush),
    .o_RegDst(reg_dst), .o_RegWrite(reg_write), .o_ALUSrc(alu_src),
    .o_MemRead(mem_read), .o_MemWrite(mem_write), .o_MemtoReg(mem_to_reg),
    .o_ALUOp(alu_op), .o_ALUCtrl(alu_ctrl), .o_select_bytes_mem_datos(sel),
    .o_flag_branch(flag), .o_stall(stall), .o_halted(halted),
    .o_contador_instrucciones(count)
  );

  // Bundle order: RegDst,RegWrite,ALUSrc,MemRead,MemWrite,MemtoReg,ALUOp,ALUCtrl,sel,flag
  wire [16:0] ctl = {reg_dst, reg_write, alu_src, mem_read, mem_write, mem_to_reg,
                     alu_op, alu_ctrl, sel, flag};

  function automatic logic [16:0] mk(input logic [5:0] b, input logic [1:0] op,
                                     input logic [3:0] ac, input logic [1:0] s,
                                     input logic [2:0] f);
    return {b, op, ac, s, f};
  endfunction

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input int sh, input logic [5:0] fn);
    return {6'b0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                        input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

`ifdef CONTROL_JAL_LINK_EN
  localparam int CNT_JAL = 9;
  localparam logic [16:0] CTL_JAL = {6'b010000, 2'b00, 4'b0000, 2'b00, 3'b101};
`else
  localparam int CNT_JAL = 8;
  localparam logic [16:0] CTL_JAL = 17'd0;
`endif

  logic [31:0] sll_i, lb_i, addu_i, sb_i, lw4_i, addi4_i, sw4_i, addi6_i, lw0_i, addu0_i;
  logic [31:0] beq_i, bad_i, jal_i, jr_i, slt_i;

  initial begin
    sll_i   = rtype(0, 1, 2, 3, 6'b000000);
    lb_i    = itype(6'b100000, 21, 1, 8);
    addu_i  = rtype(1, 2, 3, 0, 6'b100001);
    sb_i    = itype(6'b101000, 21, 1, 8);
    lw4_i   = itype(6'b100011, 2, 4, 0);
    addi4_i = itype(6'b001000, 2, 4, 1);
    sw4_i   = itype(6'b101011, 2, 4, 0);
    addi6_i = itype(6'b001000, 2, 6, 1);
    lw0_i   = itype(6'b100011, 1, 0, 0);
    addu0_i = rtype(0, 0, 3, 0, 6'b100001);
    beq_i   = itype(6'b000100, 20, 3, 9);
    bad_i   = 32'hFC00_0000;
    jal_i   = {6'b000011, 26'd7};
    jr_i    = rtype(31, 0, 0, 0, 6'b001000);
    slt_i   = rtype(2, 3, 1, 0, 6'b101010);

    rst_n = 1'b0; en = 1'b1; flush = 1'b0; instr = sll_i;
    tick(); tick();
    chk("reset_ctl", 32'(ctl), 32'd0);
    chk("reset_cnt", 32'(count), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);

    rst_n = 1'b1;
    tick();
    chk("sll_ctl", 32'(ctl), 32'(mk(6'b110000, 2'b10, 4'b1000, 2'b00, 3'b000)));
    chk("sll_cnt", 32'(count), 32'd1);

    instr = lb_i;
    tick();
    chk("lb_ctl", 32'(ctl), 32'(mk(6'b011101, 2'b00, 4'b0010, 2'b00, 3'b000)));
    instr = addu_i;
    #1 chk("lu_stall", 32'(stall), 32'd1);
    tick();
    chk("lu_bubble", 32'(ctl), 32'd0);
    chk("lu_stall_clr", 32'(stall), 32'd0);
    tick();
    chk("addu_ctl", 32'(ctl), 32'(mk(6'b110000, 2'b10, 4'b0010, 2'b00, 3'b000)));
    chk("addu_cnt", 32'(count), 32'd3);

    en = 1'b0; instr = sb_i;
    #1 chk("dis_stall", 32'(stall), 32'd0);
    tick(); tick(); tick();
    chk("dis_hold_ctl", 32'(ctl), 32'(mk(6'b110000, 2'b10, 4'b0010, 2'b00, 3'b000)));
    chk("dis_hold_cnt", 32'(count), 32'd3);
    en = 1'b1;
    tick();
    chk("sb_ctl", 32'(ctl), 32'(mk(6'b001010, 2'b00, 4'b0010, 2'b00, 3'b000)));
    chk("sb_cnt", 32'(count), 32'd4);

    instr = lw4_i;
    tick();
    chk("lw_ctl", 32'(ctl), 32'(mk(6'b011101, 2'b00, 4'b0010, 2'b11, 3'b000)));
    instr = addi4_i;
    #1 chk("addi_rt_nostall", 32'(stall), 32'd0);
    instr = sw4_i;
    #1 chk("sw_rt_stall", 32'(stall), 32'd1);
    flush = 1'b1;
    #1 chk("flush_nostall", 32'(stall), 32'd0);
    flush = 1'b0; instr = addi6_i;
    tick();
    chk("addi_ctl", 32'(ctl), 32'(mk(6'b011000, 2'b11, 4'b0010, 2'b00, 3'b000)));
    chk("addi_cnt", 32'(count), 32'd6);

    instr = lw0_i;
    tick();
    instr = addu0_i;
    #1 chk("r0_nostall", 32'(stall), 32'd0);
    chk("lw0_cnt", 32'(count), 32'd7);

    instr = beq_i; flush = 1'b1;
    tick();
    chk("flush_ctl", 32'(ctl), 32'd0);
    chk("flush_cnt", 32'(count), 32'd7);
    flush = 1'b0;
    tick();
    chk("beq_ctl", 32'(ctl), 32'(mk(6'b000000, 2'b01, 4'b0110, 2'b00, 3'b001)));
    chk("beq_cnt", 32'(count), 32'd8);

    instr = bad_i;
    tick();
    chk("bad_ctl", 32'(ctl), 32'd0);
    chk("bad_cnt", 32'(count), 32'd8);

    instr = jal_i;
    tick();
    chk("jal_ctl", 32'(ctl), 32'(CTL_JAL));
    chk("jal_cnt", 32'(count), 32'(CNT_JAL));

    instr = jr_i;
    tick();
    chk("jr_ctl", 32'(ctl), 32'(mk(6'b000000, 2'b00, 4'b0000, 2'b00, 3'b100)));
    chk("jr_cnt", 32'(count), 32'(CNT_JAL + 1));

    instr = 32'd0;
    tick();
    chk("halt_ctl", 32'(ctl), 32'd0);
    chk("halt_h0", 32'(halted), 32'd0);
    instr = slt_i; flush = 1'b1;
    tick();
    chk("drain_h1", 32'(halted), 32'd0);
    flush = 1'b0;
    tick();
    chk("drain_h2", 32'(halted), 32'd0);
    chk("drain_ctl", 32'(ctl), 32'd0);
    tick();
    chk("halted", 32'(halted), 32'd1);
    tick();
    chk("halted_ctl", 32'(ctl), 32'd0);
    chk("halted_cnt", 32'(count), 32'(CNT_JAL + 1));
    chk("halted_hold", 32'(halted), 32'd1);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; instr = 32'd0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("rst_drain_h", 32'(halted), 32'd0);
    rst_n = 1'b1; instr = slt_i;
    tick();
    chk("run_again_ctl", 32'(ctl), 32'(mk(6'b110000, 2'b10, 4'b0111, 2'b00, 3'b000)));
    chk("run_again_cnt", 32'(count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
